// File: rtl/scanline_sched_pkg.sv
// rtl/scanline_sched_pkg.sv - shared state encoding and display-list entry layout for scanline_scheduler
package scanline_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } sched_state_e;

    localparam int DATA_WIDTH = 8;
    localparam int DATA_LSB   = 0;
    localparam int ADDR_LSB   = DATA_WIDTH;

    // Entry packs {line, address, data} with data in the low bits.
    function automatic int entry_width(input int line_w, input int addr_w);
        return line_w + addr_w + DATA_WIDTH;
    endfunction

    function automatic int line_lsb(input int addr_w);
        return DATA_WIDTH + addr_w;
    endfunction

endpackage

// File: rtl/sched_list_ram.sv
// rtl/sched_list_ram.sv - display-list storage, one write port and one registered read port
module sched_list_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 25,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/scanline_scheduler.sv
// rtl/scanline_scheduler.sv - per-scanline register-write sequencer; SCANLINE_SCHED_STATS_EN adds late_count
module scanline_scheduler
    import scanline_sched_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int LINE_WIDTH = 10,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                       raw_clk,
    input  logic                       reset,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [LINE_WIDTH-1:0]      push_line,
    input  logic [ADDR_WIDTH-1:0]      push_address,
    input  logic [7:0]                 push_data,
    input  logic                       arm,
    input  logic                       clear,
    input  logic [LINE_WIDTH-1:0]      vpos,
    input  logic                       in_hblank,
    input  logic                       in_vblank,
    input  logic                       cpu_write_enable,
    output logic                       sched_write,
    output logic [ADDR_WIDTH-1:0]      sched_address,
    output logic [7:0]                 sched_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic [1:0]                 state,
    output logic                       order_error,
`ifdef SCANLINE_SCHED_STATS_EN
    output logic [7:0]                 late_count,
`endif
    output logic                       late
);

    localparam int IW       = $clog2(DEPTH);
    localparam int CW       = IW + 1;
    localparam int EW       = entry_width(LINE_WIDTH, ADDR_WIDTH);
    localparam int LINE_LSB = line_lsb(ADDR_WIDTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    sched_state_e state_q, state_n;

    logic [CW-1:0]         count_q;
    logic [CW-1:0]         idx_q, idx_n;
    logic [LINE_WIDTH-1:0] last_line_q;
    logic                  ready_en_q;
    logic                  vblank_q, hblank_q;
    logic                  edge_q, fetch_q, active_q, active_n;
    logic                  order_error_q, late_q;
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic [7:0]            last_data_q;

    logic [EW-1:0]         head;
    logic [LINE_WIDTH-1:0] head_line;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [7:0]            head_data;

    logic vb_rise, hb_rise, in_run, full, line_ok;
    logic push_fire, push_reject;
    logic head_pending, head_late, head_match, head_ahead, issue;

    assign head_line = head[LINE_LSB +: LINE_WIDTH];
    assign head_addr = head[ADDR_LSB +: ADDR_WIDTH];
    assign head_data = head[DATA_LSB +: DATA_WIDTH];

    assign vb_rise = in_vblank & ~vblank_q;
    assign hb_rise = in_hblank & ~hblank_q;
    assign in_run  = (state_q == ST_RUN);

    assign full        = (count_q == FULL_COUNT);
    assign line_ok     = (count_q == '0) || (push_line >= last_line_q);
    assign push_ready  = ready_en_q && (state_q == ST_IDLE) && !full;
    assign push_fire   = push_valid && push_ready && line_ok && !clear;
    assign push_reject = push_valid && ready_en_q && (state_q == ST_IDLE)
                         && (full || !line_ok) && !clear;

    // The registered RAM read always tracks idx_q, so its output is the head entry.
    assign head_pending = active_q && in_run && in_hblank && (idx_q != count_q);
    assign head_late    = head_pending && (head_line < vpos);
    assign head_match   = head_pending && (head_line == vpos);
    assign head_ahead   = head_pending && (head_line > vpos);
    assign issue        = head_match && !cpu_write_enable;

    sched_list_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (IW)
    ) u_list (
        .clk   (raw_clk),
        .we    (push_fire),
        .waddr (count_q[IW-1:0]),
        .wdata ({push_line, push_address, push_data}),
        .raddr (idx_n[IW-1:0]),
        .rdata (head)
    );

    always_comb begin
        state_n = state_q;
        if (clear) begin
            state_n = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (arm && count_q != '0) state_n = ST_ARMED;
                ST_ARMED: if (vb_rise) state_n = ST_RUN;
                ST_RUN:   ;
                default:  state_n = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        idx_n = idx_q;
        if (clear) begin
            idx_n = '0;
        end else if (vb_rise && (state_q == ST_ARMED || in_run)) begin
            idx_n = '0;
        end else if (issue || head_late) begin
            idx_n = idx_q + CW'(1);
        end
    end

    // edge_q -> fetch_q -> active_q gives the edge-detect and head-fetch cycles before issue.
    always_comb begin
        active_n = active_q;
        if (clear || vb_rise || !in_run) begin
            active_n = 1'b0;
        end else if (fetch_q) begin
            active_n = 1'b1;
        end else if (active_q && (!in_hblank || idx_q == count_q || head_ahead)) begin
            active_n = 1'b0;
        end
    end

    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            idx_q         <= '0;
            last_line_q   <= '0;
            ready_en_q    <= 1'b0;
            vblank_q      <= 1'b0;
            hblank_q      <= 1'b0;
            edge_q        <= 1'b0;
            fetch_q       <= 1'b0;
            active_q      <= 1'b0;
            order_error_q <= 1'b0;
            late_q        <= 1'b0;
            last_addr_q   <= '0;
            last_data_q   <= '0;
        end else begin
            state_q    <= state_n;
            idx_q      <= idx_n;
            ready_en_q <= 1'b1;
            vblank_q   <= in_vblank;
            hblank_q   <= in_hblank;
            edge_q     <= hb_rise;
            fetch_q    <= edge_q;
            active_q   <= active_n;
            if (clear) begin
                count_q       <= '0;
                order_error_q <= 1'b0;
                late_q        <= 1'b0;
            end else begin
                if (push_fire) begin
                    count_q     <= count_q + CW'(1);
                    last_line_q <= push_line;
                end
                if (push_reject) order_error_q <= 1'b1;
                if (head_late)   late_q        <= 1'b1;
            end
            if (issue) begin
                last_addr_q <= head_addr;
                last_data_q <= head_data;
            end
        end
    end

`ifdef SCANLINE_SCHED_STATS_EN
    logic [7:0] late_cnt_q;

    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            late_cnt_q <= '0;
        end else if (clear) begin
            late_cnt_q <= '0;
        end else if (head_late && late_cnt_q != 8'hFF) begin
            late_cnt_q <= late_cnt_q + 8'd1;
        end
    end

    assign late_count = late_cnt_q;
`endif

    // An in-flight write in a clear cycle still goes out; the state change stops the rest.
    assign sched_write   = issue;
    assign sched_address = issue ? head_addr : last_addr_q;
    assign sched_data    = issue ? head_data : last_data_q;
    assign count         = count_q;
    assign state         = state_q;
    assign order_error   = order_error_q;
    assign late          = late_q;

endmodule
